// File: rtl/jk_reg_bank.sv
// jk_reg_bank: bank of JK flops with load/shift/hold modes,
// a registered change flag and a saturating toggle counter.
module jk_reg_bank #(
  parameter int unsigned      WIDTH   = 8,
  parameter logic [WIDTH-1:0] RST_VAL = '0,
  parameter int unsigned      CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] j,
  input  logic [WIDTH-1:0] k,
  input  logic [WIDTH-1:0] d,
  input  logic             sin,
  input  logic             cnt_clr,
  output logic [WIDTH-1:0] q,
  output logic             sout,
  output logic             changed,
  output logic [CNT_W-1:0] tgl_cnt,
  output logic             tgl_sat
);

  localparam logic [1:0] M_JK    = 2'b00;
  localparam logic [1:0] M_LOAD  = 2'b01;
  localparam logic [1:0] M_SHIFT = 2'b10;
  localparam logic [1:0] M_HOLD  = 2'b11;

  logic [WIDTH-1:0] q_q, q_d;
  logic             chg_q, chg_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic             sat_q, sat_d;
  logic             tgl_ev;

  always_comb begin
    q_d = q_q;
    if (en) begin
      unique case (mode)
        M_JK: begin
          for (int i = 0; i < int'(WIDTH); i++) begin
            unique case ({j[i], k[i]})
              2'b01:   q_d[i] = 1'b0;
              2'b10:   q_d[i] = 1'b1;
              2'b11:   q_d[i] = ~q_q[i];
              default: q_d[i] = q_q[i];
            endcase
          end
        end
        M_LOAD:  q_d = d;
        M_SHIFT: q_d = {q_q[WIDTH-2:0], sin};
        M_HOLD:  q_d = q_q;
        default: q_d = q_q;
      endcase
    end
  end

  assign chg_d = (q_d != q_q);

  // One event per cycle no matter how many bits toggle; && masks X on j/k
  assign tgl_ev  = en && (mode == M_JK) && (|(j & k));
  assign cnt_inc = cnt_q + 1'b1;

  always_comb begin
    cnt_d = cnt_q;
    sat_d = sat_q;
    if (cnt_clr) begin
      cnt_d = '0;
      sat_d = 1'b0;
    end else if (tgl_ev && (cnt_q != '1)) begin
      cnt_d = cnt_inc;
      sat_d = sat_q | (cnt_inc == '1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q   <= RST_VAL;
      chg_q <= 1'b0;
      cnt_q <= '0;
      sat_q <= 1'b0;
    end else begin
      q_q   <= q_d;
      chg_q <= chg_d;
      cnt_q <= cnt_d;
      sat_q <= sat_d;
    end
  end

  assign q       = q_q;
  assign sout    = q_q[WIDTH-1];
  assign changed = chg_q;
  assign tgl_cnt = cnt_q;
  assign tgl_sat = sat_q;

endmodule

// File: tb/tb_jk_reg_bank.sv
// Directed bench for jk_reg_bank with a behavioural model
// feeding an expected-result queue checked after each edge.
module tb_jk_reg_bank;

  localparam int         W  = 8;
  localparam int         CW = 3;
  localparam logic [7:0] RV = 8'hA5;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          en = 1'b0;
  logic [1:0]    mode = 2'b11;
  logic [W-1:0]  j = '0, k = '0, d = '0;
  logic          sin = 1'b0, cnt_clr = 1'b0;
  logic [W-1:0]  q;
  logic          sout, changed, tgl_sat;
  logic [CW-1:0] tgl_cnt;

  typedef struct {
    string         tag;
    logic [W-1:0]  q;
    logic          chg;
    logic [CW-1:0] cnt;
    logic          sat;
  } exp_t;

  exp_t sb[$];

  logic [W-1:0]  mq;
  logic [CW-1:0] mcnt;
  logic          msat;

  int n_chk = 0;
  int n_fail = 0;

  jk_reg_bank #(.WIDTH(W), .RST_VAL(RV), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode),
    .j(j), .k(k), .d(d), .sin(sin), .cnt_clr(cnt_clr),
    .q(q), .sout(sout), .changed(changed),
    .tgl_cnt(tgl_cnt), .tgl_sat(tgl_sat)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq   = RV;
    mcnt = '0;
    msat = 1'b0;
  endtask

  task automatic cyc(input string tag, input logic e,
                     input logic [1:0] m, input logic [W-1:0] jj,
                     input logic [W-1:0] kk, input logic [W-1:0] dd,
                     input logic s, input logic clr);
    exp_t x;
    logic [W-1:0] nq;
    logic ev;
    en = e; mode = m; j = jj; k = kk; d = dd;
    sin = s; cnt_clr = clr;
    nq = mq;
    ev = 1'b0;
    if (e) begin
      case (m)
        2'b00: for (int i = 0; i < W; i++) begin
          if (jj[i] && kk[i]) begin
            nq[i] = ~mq[i];
            ev = 1'b1;
          end else if (jj[i]) nq[i] = 1'b1;
          else if (kk[i]) nq[i] = 1'b0;
        end
        2'b01: nq = dd;
        2'b10: nq = {mq[W-2:0], s};
        default: nq = mq;
      endcase
    end
    x.tag = tag;
    x.chg = (nq != mq);
    if (clr) begin
      mcnt = '0;
      msat = 1'b0;
    end else if (ev && mcnt != {CW{1'b1}}) begin
      mcnt = mcnt + 1'b1;
      if (mcnt == {CW{1'b1}}) msat = 1'b1;
    end
    mq = nq;
    x.q = mq; x.cnt = mcnt; x.sat = msat;
    sb.push_back(x);
    @(posedge clk);
    #1;
    x = sb.pop_front();
    chk({x.tag, ".q"}, 32'(q), 32'(x.q));
    chk({x.tag, ".changed"}, 32'(changed), 32'(x.chg));
    chk({x.tag, ".cnt"}, 32'(tgl_cnt), 32'(x.cnt));
    chk({x.tag, ".sat"}, 32'(tgl_sat), 32'(x.sat));
  endtask

  initial begin
    model_reset();
    // 1: asynchronous reset between edges
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("rst.q", 32'(q), 32'h A5);
    chk("rst.changed", 32'(changed), 32'h0);
    chk("rst.cnt", 32'(tgl_cnt), 32'h0);
    chk("rst.sat", 32'(tgl_sat), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // 2: JK set/clear then toggle all
    cyc("ld00", 1, 2'b01, 8'h00, 8'h00, 8'h00, 0, 0);
    cyc("jk_set", 1, 2'b00, 8'hF0, 8'h0F, 8'h00, 0, 0);
    chk("jk_set.lit", 32'(q), 32'h F0);
    cyc("jk_tgl", 1, 2'b00, 8'hFF, 8'hFF, 8'h00, 0, 0);
    chk("jk_tgl.lit", 32'(q), 32'h 0F);
    chk("jk_tgl.cnt1", 32'(tgl_cnt), 32'h1);

    // 3: load then shift, sout before each edge
    cyc("ld81", 1, 2'b01, 'x, 'x, 8'h81, 0, 0);
    chk("sout0", 32'(sout), 32'h1);
    cyc("sh1", 1, 2'b10, 'x, 'x, 8'h00, 1, 0);
    chk("sh1.lit", 32'(q), 32'h03);
    chk("sout1", 32'(sout), 32'h0);
    cyc("sh2", 1, 2'b10, 'x, 'x, 8'h00, 0, 0);
    cyc("sh3", 1, 2'b10, 'x, 'x, 8'h00, 1, 0);
    chk("sh3.lit", 32'(q), 32'h0D);

    // 4: hold mode and en=0
    cyc("ld3c", 1, 2'b01, 8'h00, 8'h00, 8'h3C, 0, 0);
    cyc("hold1", 1, 2'b11, 8'hFF, 8'hFF, 8'h00, 0, 0);
    cyc("hold2", 1, 2'b11, 8'hFF, 8'hFF, 8'h00, 0, 0);
    cyc("en0", 0, 2'b00, 8'hFF, 8'hFF, 8'h00, 0, 0);
    chk("en0.lit", 32'(q), 32'h3C);
    chk("en0.cnt", 32'(tgl_cnt), 32'h1);

    // 5: saturation and clear-wins
    cyc("clr", 0, 2'b00, 8'h00, 8'h00, 8'h00, 0, 1);
    for (int i = 1; i <= 9; i++) begin
      cyc($sformatf("tg%0d", i), 1, 2'b00, 8'h01, 8'h01,
          8'h00, 0, 0);
      chk($sformatf("tg%0d.lit", i), 32'(tgl_cnt),
          32'((i > 7) ? 7 : i));
      chk($sformatf("tg%0d.satl", i), 32'(tgl_sat),
          32'(i >= 7));
    end
    cyc("clr_tg", 1, 2'b00, 8'hFF, 8'hFF, 8'h00, 0, 1);
    chk("clr_tg.lit", 32'({tgl_sat, tgl_cnt}), 32'h0);

    // 6: reset while shifting
    cyc("ld5a", 1, 2'b01, 8'h00, 8'h00, 8'h5A, 0, 0);
    en = 1'b1; mode = 2'b10; sin = 1'b1;
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    chk("mid.q", 32'(q), 32'h A5);
    chk("mid.changed", 32'(changed), 32'h0);
    chk("mid.cnt", 32'(tgl_cnt), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc("post", 0, 2'b10, 8'h00, 8'h00, 8'h00, 1, 0);
    chk("post.lit", 32'(q), 32'h A5);

    chk("sb.empty", 32'(sb.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/jk_reg_bank.md
Name: jk_reg_bank

Overview:
- Parametrised bank of WIDTH JK flip-flops with per-bit J/K inputs and a shared clock enable.
- Extends the single-bit JK flip-flop with three extra modes: parallel load, serial shift and explicit hold.
- Adds a registered change flag and a saturating toggle-event counter for observability.
- Used as a general control/status register wherever per-bit set/clear/toggle semantics are needed.

Parameters:
WIDTH, 8, number of JK bits in the bank (>=2)
RST_VAL, {WIDTH{1'b0}}, value loaded into q on reset
CNT_W, 8, width of the toggle-event counter (>=2)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  reset: asynchronous, active-low
en  input  1  synchronous enable; 0 = hold all state except the counter clear
mode  input  2  00 JK, 01 parallel load, 10 shift left, 11 hold
j  input  WIDTH  per-bit J (JK mode only)
k  input  WIDTH  per-bit K (JK mode only)
d  input  WIDTH  parallel load data (mode 01)
sin  input  1  serial input into bit 0 (mode 10)
cnt_clr  input  1  synchronous clear of tgl_cnt and tgl_sat
q  output  WIDTH  register bank state
sout  output  1  combinational copy of q[WIDTH-1]
changed  output  1  registered; 1 for one cycle after any q bit changed value
tgl_cnt  output  CNT_W  number of toggle events, saturating
tgl_sat  output  1  sticky; set when tgl_cnt reaches all-ones

Behaviour:
- Reset (rst_n=0, asynchronous, takes effect immediately without waiting for a clock edge):
  - q=RST_VAL, changed=0, tgl_cnt=0, tgl_sat=0.
  - Once released, operation resumes from reset values on the first rising clk edge.
- All state updates on the rising clk edge. Next state is computed from the current q and inputs each cycle; q_next must be fully combinational on q, j, k, d, sin, mode and en, with no latches.
- Mode behaviour when en=1, evaluated per bit i:
  - mode 00 (JK): {j[i],k[i]} = 00 hold; 01 q[i]<=0; 10 q[i]<=1; 11 q[i]<=~q[i].
  - mode 01 (load): q<=d. j and k are ignored.
  - mode 10 (shift): q<={q[WIDTH-2:0],sin}. The old q[WIDTH-1] is lost; sout shows it before the edge.
  - mode 11 (hold): q unchanged.
- en=0: q holds regardless of mode. changed<=0. The counter holds unless cnt_clr=1.
- changed <= (q_next != q) on every edge, so it is 0 whenever en=0.
- Toggle event: en=1, mode=00, and at least one bit has j=k=1.
  - Counts one event per cycle, regardless of how many bits toggle.
- Counter update priority per edge:
  1. cnt_clr=1: tgl_cnt<=0, tgl_sat<=0. This wins even if a toggle event occurs in the same cycle.
  2. Toggle event and tgl_cnt != all-ones: tgl_cnt<=tgl_cnt+1. If the new value is all-ones, tgl_sat<=1 on the same edge.
  3. Toggle event at all-ones: tgl_cnt stays all-ones (no wrap); tgl_sat stays 1.
- Latency: q, changed, tgl_cnt and tgl_sat are all valid one cycle after the inputs are sampled. sout has zero latency from q.
- Reset asserted mid-operation, including mid-shift or during counter saturation, clears everything immediately. No partial update may be applied on the reset-release edge.
- X on j/k for a bit is a don't-care when mode != 00 or en=0.

Test Plan:
1. Reset check, WIDTH=8, RST_VAL=8'hA5: assert rst_n=0 between clock edges.
   -> q=A5, changed=0, tgl_cnt=0 immediately, without waiting for a clk edge.
2. JK mode: q=00, apply j=F0, k=0F. Next cycle apply j=FF, k=FF.
   -> q=F0 with changed=1, then q=0F with changed=1 and tgl_cnt=1.
3. Load then shift: mode 01, d=81. Then mode 10 for 3 cycles with sin=1,0,1.
   -> q=81, then 03, 06, 0D. sout=1 before the first shift edge, then 0.
4. Hold and enable: q=3C; mode 11 for 2 cycles, then en=0 with mode 00 and j=k=FF.
   -> q stays 3C, changed=0 throughout, tgl_cnt unchanged.
5. Counter saturation, CNT_W=3: 9 consecutive toggle cycles.
   -> tgl_cnt goes 1..7; tgl_sat=1 on the 7th edge; cnt stays 7 on cycles 8-9.
   -> Then cnt_clr=1 together with a toggle event gives tgl_cnt=0, tgl_sat=0.
6. Reset mid-operation: drop rst_n while shifting q=5A at mode 10.
   -> q=RST_VAL immediately. First edge after release with en=0 keeps q=RST_VAL and changed=0.
